timer_arb: RTL and testbench
============================

TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000, maximum clk cycles spent in WAIT before abort (used only when TIMER_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 level request for one timer sample.
REQ-005 req1  input  1  requester 1 level request for one timer sample.
REQ-006 gnt0  output  1  requester 0 owns the timer.
REQ-007 gnt1  output  1  requester 1 owns the timer.
REQ-008 done0  output  1  one-cycle pulse, requester 0 transaction complete.
REQ-009 done1  output  1  one-cycle pulse, requester 1 transaction complete.
REQ-010 data_out  output  16  last captured timer value.
REQ-011 err  output  1  one-cycle pulse with done when transaction timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 t_en  output  1  start strobe to the timer.
REQ-014 t_valid  input  1  timer output valid.
REQ-015 t_out  input  16  timer value.

Function
REQ-016 FSM states IDLE, START, WAIT, DONE; encoding free.
REQ-017 IDLE: no req -> stay; any req high -> select owner, assert its gnt, go START next edge.
REQ-018 Arbitration round-robin: both req high -> requester not served last wins; after reset requester 0 has priority.
REQ-019 START: t_en high for exactly this one cycle; next state WAIT.
REQ-020 WAIT: t_valid high -> data_out <= t_out, next state DONE; t_valid low -> stay.
REQ-021 t_valid outside WAIT ignored; data_out unchanged.
REQ-022 DONE: owner's done high for exactly one cycle; gnt deasserted on exit; last-served pointer updated; next state IDLE.
REQ-023 gnt0/gnt1 one-hot or zero; high continuously START through DONE for the owner only.
REQ-024 Latency: req sampled at edge N -> gnt high and t_en high in cycle N+1; t_valid at edge M in WAIT -> data_out and done valid in cycle M+1.
REQ-025 Owner dropping req after grant: transaction completes normally, done still pulsed.
REQ-026 Owner holding req through DONE: re-arbitrated in IDLE; other pending requester served first.
REQ-027 data_out 16 bits, captured verbatim, no arithmetic; holds value until next capture.
REQ-028 Minimum transaction 4 cycles (IDLE, START, WAIT, DONE) when t_valid high in first WAIT cycle.

Reset
REQ-029 rst low: immediately, independent of clk: state IDLE, gnt0=gnt1=0, done0=done1=0, t_en=0, err=0, busy=0, data_out=16'h0000, pointer = requester 0 priority, timeout counter 0.
REQ-030 rst asserted mid-transaction aborts it; no done pulse for the aborted transaction; after release first req accepted per REQ-017.

Configuration
REQ-031 Macro TIMER_ARB_TIMEOUT_EN defined: WAIT counts cycles from 0; reaching TIMEOUT_CYC-1 without t_valid -> go DONE, data_out unchanged, err pulsed together with owner's done; counter cleared on entering WAIT.
REQ-032 TIMER_ARB_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, err tied to 0.
REQ-033 t_valid and timeout in same cycle: t_valid wins, data captured, err low.

Verification
REQ-034 req0 high alone, t_valid with t_out=16'h0005 two cycles after t_en -> gnt0 one cycle after req, single t_en pulse, data_out=16'h0005, done0 one pulse, gnt1 never high.
REQ-035 req0 and req1 high together from reset, held -> service order 0,1,0,1; data_out tracks t_out=16'h0010,16'h0011,16'h0012,16'h0013.
REQ-036 req1 pulsed one cycle then dropped -> transaction completes, done1 pulsed, data_out=t_out=16'hFFFF.
REQ-037 rst low during WAIT -> all outputs at reset values same cycle, no done; after release req0 served normally.
REQ-038 TIMER_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, t_valid never -> DONE after 8 WAIT cycles, err and done0 pulsed together, data_out unchanged.
REQ-039 t_valid pulsed in IDLE with t_out=16'h1234 -> data_out stays 16'h0000, no done.

Source files
------------

// File: rtl/timer_arb_if.sv
// Timer-side handshake of the timer arbiter: start strobe out,
// valid/value back from the shared timer.
interface timer_arb_if;
    logic        t_en;
    logic        t_valid;
    logic [15:0] t_out;

    modport master (
        output t_en,
        input  t_valid,
        input  t_out
    );

    modport slave (
        input  t_en,
        output t_valid,
        output t_out
    );
endinterface

// File: rtl/timer_arb.sv
// Round-robin arbiter giving two requesters one timer sample each.
// Optional WAIT timeout enabled by defining TIMER_ARB_TIMEOUT_EN.
module timer_arb #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] data_out,
    output logic        err,
    output logic        busy,
    timer_arb_if.master tmr
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   owner_nxt;
    logic   last;
    logic   timeout_hit;

    // last == 1 after reset so requester 0 wins the first tie
    always_comb begin
        owner_nxt = req1;
        if (req0 && req1) begin
            owner_nxt = ~last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            data_out <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                owner <= owner_nxt;
            end
            if (state == DONE) begin
                last <= owner;
            end
            if (state == WAIT && tmr.t_valid) begin
                data_out <= tmr.t_out;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tmr.t_valid || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        gnt0     = busy && !owner;
        gnt1     = busy && owner;
        tmr.t_en = (state == START);
        done0    = (state == DONE) && !owner;
        done1    = (state == DONE) && owner;
    end

`ifdef TIMER_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt;
    logic          to_flag;

    assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));

    // held at zero outside WAIT so each WAIT starts counting from 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state != WAIT) begin
                cnt <= '0;
            end else if (!timeout_hit) begin
                cnt <= cnt + 1'b1;
            end
            if (state == WAIT) begin
                to_flag <= timeout_hit && !tmr.t_valid;
            end else if (state == IDLE) begin
                to_flag <= 1'b0;
            end
        end
    end

    assign err = (state == DONE) && to_flag;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_timer_arb.sv
// Randomized scoreboard bench for timer_arb against a
// transaction-level arbitration model.
module tb_timer_arb;

    localparam int TMO = 8;

    typedef struct {
        bit          owner;
        logic [15:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] data_out;
    logic        err;
    logic        busy;

    timer_arb_if tif ();

    timer_arb #(
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .data_out (data_out),
        .err      (err),
        .busy     (busy),
        .tmr      (tif)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_push = 0;
    int          n_done = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          last_srv = 1'b1;
    logic [15:0] cur_data = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_gnt"}, 32'({gnt1, gnt0}), 0);
        chk({nm, "_done"}, 32'({done1, done0}), 0);
        chk({nm, "_t_en"}, 32'(tif.t_en), 0);
        chk({nm, "_err"}, 32'(err), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    // scoreboard monitor: every done pulse must match the queue head
    always @(negedge clk) begin
        if (rst) begin
            chk("gnt_onehot", 32'(gnt0 & gnt1), 0);
            if (done0 || done1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'({done1, done0}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_done++;
                    chk("done_owner", 32'({done1, done0}),
                        mon_e.owner ? 2 : 1);
                    chk("done_gnt", 32'({gnt1, gnt0}),
                        mon_e.owner ? 2 : 1);
                    chk("done_data", 32'(data_out), 32'(mon_e.data));
                    chk("done_err", 32'(err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic do_txn(input bit r0, input bit r1, input int dly,
                          input logic [15:0] val, input bit drop,
                          input bit tmo, output bit won);
        bit       w;
        logic [1:0] g;
        @(negedge clk);
        chk("idle_pre_busy", 32'(busy), 0);
        chk("idle_pre_done", 32'({done1, done0}), 0);
        req0 = r0;
        req1 = r1;
        w = (r0 && r1) ? !last_srv : r1;
        g = w ? 2'b10 : 2'b01;
        @(negedge clk);
        won = gnt1;
        chk("grant", 32'({gnt1, gnt0}), 32'(g));
        chk("t_en_start", 32'(tif.t_en), 1);
        exp_q.push_back('{owner: w, data: tmo ? cur_data : val, err: tmo});
        n_push++;
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        @(negedge clk);
        chk("t_en_single", 32'(tif.t_en), 0);
        chk("busy_wait", 32'(busy), 1);
        chk("gnt_wait", 32'({gnt1, gnt0}), 32'(g));
        if (tmo) begin
            tif.t_out = val;
            repeat (TMO) @(negedge clk);
        end else begin
            repeat (dly) @(negedge clk);
            tif.t_valid = 1'b1;
            tif.t_out   = val;
            @(negedge clk);
            tif.t_valid = 1'b0;
            tif.t_out   = 16'($urandom);
            cur_data    = val;
        end
        chk("done_latency", 32'({done1, done0}), 32'(g));
        chk("data_latency", 32'(data_out), 32'(cur_data));
        last_srv = w;
    endtask

    initial begin
        bit won;
        tif.t_valid = 1'b0;
        tif.t_out   = 16'h0000;
        #1;
        chk_idle("reset");
        chk("reset_data", 32'(data_out), 0);
        req0 = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset_held");
        req0 = 1'b0;
        rst  = 1'b1;

        // t_valid while IDLE must not capture
        @(negedge clk);
        tif.t_out   = 16'h1234;
        tif.t_valid = 1'b1;
        @(negedge clk);
        tif.t_valid = 1'b0;
        chk("idle_tvalid_data", 32'(data_out), 0);
        chk_idle("idle_tvalid");

        // both held from reset: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, 0, 16'h0010 + 16'(i), 1'b0, 1'b0, won);
            chk("rr_order", 32'(won), 32'(i % 2));
        end

        do_txn(1'b1, 1'b0, 1, 16'h0005, 1'b0, 1'b0, won);
        chk("req0_alone", 32'(won), 0);
        do_txn(1'b0, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0, won);
        chk("req1_pulse", 32'(won), 1);

        // reset in the middle of WAIT
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        chk("rst_mid_grant", 32'({gnt1, gnt0}), 1);
        req0 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_data", 32'(data_out), 0);
        @(negedge clk);
        rst      = 1'b1;
        last_srv = 1'b1;
        cur_data = 16'h0000;
        do_txn(1'b1, 1'b0, 0, 16'h00A5, 1'b0, 1'b0, won);
        chk("post_rst_owner", 32'(won), 0);

        for (int i = 0; i < 40; i++) begin
            bit r0;
            bit r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) begin
                @(negedge clk);
                req0 = 1'b0;
                req1 = 1'b0;
                @(negedge clk);
                chk_idle("rand_idle");
            end else begin
                do_txn(r0, r1, int'($urandom_range(0, 4)),
                       16'($urandom), 1'($urandom), 1'b0, won);
            end
        end

`ifdef TIMER_ARB_TIMEOUT_EN
        do_txn(1'b1, 1'b0, 0, 16'($urandom), 1'b0, 1'b1, won);
        do_txn(1'b1, 1'b1, 0, 16'($urandom), 1'b0, 1'b1, won);
        do_txn(1'b0, 1'b1, TMO - 1, 16'hBEEF, 1'b0, 1'b0, won);
`endif

        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("done_count", 32'(n_done), 32'(n_push));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
